// File: rtl/coreboard1588_regs_pkg.sv
// Shared address map, field types and constants for the Coreboard1588 register bank.
`timescale 1ns/1ps
package coreboard1588_regs_pkg;

  localparam int ADDR_PRODUCT_ID = 1;
  localparam int ADDR_SCRATCH    = 8;
  localparam int ADDR_RTC_MODE   = 16;
  localparam int ADDR_SECOND     = 17;
  localparam int ADDR_NANOSECOND = 18;
  localparam int ADDR_TIMESET    = 19;
  localparam int ADDR_TIMEGET    = 20;
  localparam int ADDR_SNAP_SEC   = 21;
  localparam int ADDR_SNAP_NS    = 22;
  localparam int ADDR_SECOND_INC = 23;
  localparam int ADDR_IRQ_STATUS = 24;
  localparam int ADDR_IRQ_MASK   = 25;
  localparam int ADDR_TRIG_BASE  = 64;
  localparam int TRIG_STRIDE     = 8;

  localparam logic [2:0] OFF_CTRL       = 3'd0;
  localparam logic [2:0] OFF_SHADOW_SEC = 3'd1;
  localparam logic [2:0] OFF_SHADOW_NS  = 3'd2;
  localparam logic [2:0] OFF_COMMIT     = 3'd3;
  localparam logic [2:0] OFF_ACTIVE_SEC = 3'd4;
  localparam logic [2:0] OFF_ACTIVE_NS  = 3'd5;
  localparam logic [2:0] OFF_FIRE_CNT   = 3'd6;

  typedef enum logic [1:0] {
    SRC_MCU = 2'b00,
    SRC_RTC = 2'b11
  } trig_src_t;

  typedef logic [1:0] trig_type_t;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/coreboard1588_trig_chan_regs.sv
// One trigger channel: ctrl fields, shadow/active compare time with commit, saturating fire counter.
`timescale 1ns/1ps
module coreboard1588_trig_chan_regs
  import coreboard1588_regs_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_off,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  input  logic        fired,
  output logic        enable,
  output trig_src_t   source,
  output trig_type_t  ttype,
  output logic [31:0] act_sec,
  output logic [31:0] act_ns,
  output logic        load
);

  logic [31:0]          shadow_sec;
  logic [31:0]          shadow_ns;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      enable     <= 1'b0;
      source     <= SRC_MCU;
      ttype      <= '0;
      shadow_sec <= '0;
      shadow_ns  <= '0;
      act_sec    <= '0;
      act_ns     <= '0;
      load       <= 1'b0;
      cnt        <= '0;
    end else begin
      load <= 1'b0;
      if (wr_en) begin
        case (wr_off)
          OFF_CTRL: begin
            enable <= wr_data[0];
            source <= trig_src_t'(wr_data[2:1]);
            ttype  <= wr_data[5:4];
          end
          OFF_SHADOW_SEC: shadow_sec <= wr_data;
          OFF_SHADOW_NS:  shadow_ns  <= wr_data;
          // Both halves move together so the trigger unit never sees a torn time.
          OFF_COMMIT: if (wr_data[0]) begin
            act_sec <= shadow_sec;
            act_ns  <= shadow_ns;
            load    <= 1'b1;
          end
          default: ;
        endcase
      end
      // A clear that lands on a fire still counts that fire.
      if (wr_en && wr_off == OFF_FIRE_CNT)
        cnt <= CNT_WIDTH'(fired);
      else if (fired && cnt != '1)
        cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    case (rd_off)
      OFF_CTRL:       rd_data = {26'd0, ttype, 1'b0, source, enable};
      OFF_SHADOW_SEC: rd_data = shadow_sec;
      OFF_SHADOW_NS:  rd_data = shadow_ns;
      OFF_COMMIT:     rd_data = '0;
      OFF_ACTIVE_SEC: rd_data = act_sec;
      OFF_ACTIVE_NS:  rd_data = act_ns;
      OFF_FIRE_CNT:   rd_data = 32'(cnt);
      default:        rd_hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/coreboard1588_trig_regs.sv
// Coreboard1588 RTC + NUM_TRIG trigger register bank on the up_* bus.
// Optional W1C interrupts (addresses 24/25 and irq) are enabled by COREBOARD1588_TRIG_IRQ_EN.
`timescale 1ns/1ps
module coreboard1588_trig_regs
  import coreboard1588_regs_pkg::*;
#(
  parameter int          C_ADDR_WIDTH = 10,
  parameter int          NUM_TRIG     = 4,
  parameter int          CNT_WIDTH    = 16,
  parameter logic [31:0] PRODUCT_ID   = 32'h1588_0002
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_ADDR_WIDTH-1:0]       up_wr_addr,
  input  logic                          up_wr_req,
  input  logic [31:0]                   up_wr_din,
  output logic                          up_wr_ack,
  input  logic [C_ADDR_WIDTH-1:0]       up_rd_addr,
  input  logic                          up_rd_req,
  output logic [31:0]                   up_rd_dout,
  output logic                          up_rd_ack,
  output logic [31:0]                   ctrl_scratch,
  output logic                          ctrl_rtc_mode,
  output logic [31:0]                   ctrl_second,
  output logic [31:0]                   ctrl_nanosecond,
  output logic                          ctrl_timeset,
  output logic                          ctrl_timeget,
  output logic                          ctrl_second_inc,
  input  logic [31:0]                   stat_second,
  input  logic [31:0]                   stat_nanosecond,
  output logic [NUM_TRIG-1:0]           ctrl_trig_enable,
  output logic [NUM_TRIG-1:0][1:0]      ctrl_trig_source,
  output logic [NUM_TRIG-1:0][1:0]      ctrl_trig_type,
  output logic [NUM_TRIG-1:0][31:0]     ctrl_trig_second,
  output logic [NUM_TRIG-1:0][31:0]     ctrl_trig_nanosecond,
  output logic [NUM_TRIG-1:0]           ctrl_trig_load,
  input  logic [NUM_TRIG-1:0]           stat_trig_fired,
  output logic                          irq
);

  localparam int AW = C_ADDR_WIDTH;

  // Bus handshake: a req is a single-cycle pulse; its ack is that pulse delayed one
  // cycle, with read data valid alongside the ack. No back-pressure on either side.
  logic [31:0]                 snap_ns;
  logic [31:0]                 rd_next;
  logic [NUM_TRIG-1:0]         chan_wr;
  logic [NUM_TRIG-1:0]         chan_rd_sel;
  logic [NUM_TRIG-1:0]         chan_hit;
  logic [NUM_TRIG-1:0][31:0]   chan_rd_data;

  for (genvar k = 0; k < NUM_TRIG; k++) begin : g_chan
    localparam logic [AW-4:0] BLK = (AW-3)'((ADDR_TRIG_BASE + TRIG_STRIDE * k) / TRIG_STRIDE);
    trig_src_t src_k;

    assign chan_wr[k]          = up_wr_req && (up_wr_addr[AW-1:3] == BLK);
    assign chan_rd_sel[k]      = (up_rd_addr[AW-1:3] == BLK);
    assign ctrl_trig_source[k] = src_k;

    coreboard1588_trig_chan_regs #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (chan_wr[k]),
      .wr_off  (up_wr_addr[2:0]),
      .wr_data (up_wr_din),
      .rd_off  (up_rd_addr[2:0]),
      .rd_data (chan_rd_data[k]),
      .rd_hit  (chan_hit[k]),
      .fired   (stat_trig_fired[k]),
      .enable  (ctrl_trig_enable[k]),
      .source  (src_k),
      .ttype   (ctrl_trig_type[k]),
      .act_sec (ctrl_trig_second[k]),
      .act_ns  (ctrl_trig_nanosecond[k]),
      .load    (ctrl_trig_load[k])
    );
  end

`ifdef COREBOARD1588_TRIG_IRQ_EN
  logic [NUM_TRIG-1:0] irq_status, irq_status_nxt;
  logic [NUM_TRIG-1:0] irq_mask, irq_mask_nxt;

  // New fires win over a same-cycle clear so no event is lost.
  always_comb begin
    irq_status_nxt = irq_status;
    irq_mask_nxt   = irq_mask;
    if (up_wr_req && up_wr_addr == AW'(ADDR_IRQ_STATUS))
      irq_status_nxt = irq_status_nxt & ~up_wr_din[NUM_TRIG-1:0];
    irq_status_nxt = irq_status_nxt | stat_trig_fired;
    if (up_wr_req && up_wr_addr == AW'(ADDR_IRQ_MASK))
      irq_mask_nxt = up_wr_din[NUM_TRIG-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_status <= '0;
      irq_mask   <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= irq_status_nxt;
      irq_mask   <= irq_mask_nxt;
      irq        <= |(irq_status_nxt & irq_mask_nxt);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_next = DEADBEEF;
    case (up_rd_addr)
      AW'(ADDR_PRODUCT_ID): rd_next = PRODUCT_ID;
      AW'(ADDR_SCRATCH):    rd_next = ctrl_scratch;
      AW'(ADDR_RTC_MODE):   rd_next = {31'd0, ctrl_rtc_mode};
      AW'(ADDR_SECOND):     rd_next = ctrl_second;
      AW'(ADDR_NANOSECOND): rd_next = ctrl_nanosecond;
      AW'(ADDR_TIMESET),
      AW'(ADDR_TIMEGET),
      AW'(ADDR_SECOND_INC): rd_next = '0;
      AW'(ADDR_SNAP_SEC):   rd_next = stat_second;
      AW'(ADDR_SNAP_NS):    rd_next = snap_ns;
`ifdef COREBOARD1588_TRIG_IRQ_EN
      AW'(ADDR_IRQ_STATUS): rd_next = 32'(irq_status);
      AW'(ADDR_IRQ_MASK):   rd_next = 32'(irq_mask);
`endif
      default: ;
    endcase
    for (int k = 0; k < NUM_TRIG; k++)
      if (chan_rd_sel[k] && chan_hit[k]) rd_next = chan_rd_data[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_wr_ack       <= 1'b0;
      up_rd_ack       <= 1'b0;
      up_rd_dout      <= '0;
      ctrl_scratch    <= '0;
      ctrl_rtc_mode   <= 1'b0;
      ctrl_second     <= '0;
      ctrl_nanosecond <= '0;
      ctrl_timeset    <= 1'b0;
      ctrl_timeget    <= 1'b0;
      ctrl_second_inc <= 1'b0;
      snap_ns         <= '0;
    end else begin
      up_wr_ack       <= up_wr_req;
      up_rd_ack       <= up_rd_req;
      ctrl_timeset    <= up_wr_req && up_wr_addr == AW'(ADDR_TIMESET)    && up_wr_din[0];
      ctrl_timeget    <= up_wr_req && up_wr_addr == AW'(ADDR_TIMEGET)    && up_wr_din[0];
      ctrl_second_inc <= up_wr_req && up_wr_addr == AW'(ADDR_SECOND_INC) && up_wr_din[0];
      if (up_wr_req) begin
        case (up_wr_addr)
          AW'(ADDR_SCRATCH):    ctrl_scratch    <= up_wr_din;
          AW'(ADDR_RTC_MODE):   ctrl_rtc_mode   <= up_wr_din[0];
          AW'(ADDR_SECOND):     ctrl_second     <= up_wr_din;
          AW'(ADDR_NANOSECOND): ctrl_nanosecond <= up_wr_din;
          default: ;
        endcase
      end
      // Capturing ns on the seconds read makes the following ns read coherent with it.
      if (up_rd_req) begin
        up_rd_dout <= rd_next;
        if (up_rd_addr == AW'(ADDR_SNAP_SEC)) snap_ns <= stat_nanosecond;
      end
    end
  end

endmodule

// File: tb/tb_coreboard1588_trig_regs.sv
// Self-checking bench for coreboard1588_trig_regs: register vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_coreboard1588_trig_regs;

  localparam int AW = 10;
  localparam int NT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [AW-1:0]     up_wr_addr = '0;
  logic              up_wr_req = 1'b0;
  logic [31:0]       up_wr_din = '0;
  logic              up_wr_ack;
  logic [AW-1:0]     up_rd_addr = '0;
  logic              up_rd_req = 1'b0;
  logic [31:0]       up_rd_dout;
  logic              up_rd_ack;
  logic [31:0]       ctrl_scratch, ctrl_second, ctrl_nanosecond;
  logic              ctrl_rtc_mode, ctrl_timeset, ctrl_timeget, ctrl_second_inc;
  logic [31:0]       stat_second = '0;
  logic [31:0]       stat_nanosecond = '0;
  logic [NT-1:0]         ctrl_trig_enable, ctrl_trig_load;
  logic [NT-1:0][1:0]    ctrl_trig_source, ctrl_trig_type;
  logic [NT-1:0][31:0]   ctrl_trig_second, ctrl_trig_nanosecond;
  logic [NT-1:0]         stat_trig_fired = '0;
  logic                  irq;

  // Narrow-counter instance sharing the bus inputs.
  logic              d2_wr_ack, d2_rd_ack;
  logic [31:0]       d2_rd_dout, d2_scratch, d2_second, d2_nanosecond;
  logic              d2_rtc_mode, d2_timeset, d2_timeget, d2_second_inc;
  logic [0:0]        d2_trig_enable, d2_trig_load;
  logic [0:0][1:0]   d2_trig_source, d2_trig_type;
  logic [0:0][31:0]  d2_trig_second, d2_trig_nanosecond;
  logic              d2_irq;

  coreboard1588_trig_regs #(.C_ADDR_WIDTH(AW), .NUM_TRIG(NT), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .up_wr_addr(up_wr_addr), .up_wr_req(up_wr_req), .up_wr_din(up_wr_din), .up_wr_ack(up_wr_ack),
    .up_rd_addr(up_rd_addr), .up_rd_req(up_rd_req), .up_rd_dout(up_rd_dout), .up_rd_ack(up_rd_ack),
    .ctrl_scratch(ctrl_scratch), .ctrl_rtc_mode(ctrl_rtc_mode),
    .ctrl_second(ctrl_second), .ctrl_nanosecond(ctrl_nanosecond),
    .ctrl_timeset(ctrl_timeset), .ctrl_timeget(ctrl_timeget), .ctrl_second_inc(ctrl_second_inc),
    .stat_second(stat_second), .stat_nanosecond(stat_nanosecond),
    .ctrl_trig_enable(ctrl_trig_enable), .ctrl_trig_source(ctrl_trig_source),
    .ctrl_trig_type(ctrl_trig_type), .ctrl_trig_second(ctrl_trig_second),
    .ctrl_trig_nanosecond(ctrl_trig_nanosecond), .ctrl_trig_load(ctrl_trig_load),
    .stat_trig_fired(stat_trig_fired), .irq(irq)
  );

  coreboard1588_trig_regs #(.C_ADDR_WIDTH(AW), .NUM_TRIG(1), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .up_wr_addr(up_wr_addr), .up_wr_req(up_wr_req), .up_wr_din(up_wr_din), .up_wr_ack(d2_wr_ack),
    .up_rd_addr(up_rd_addr), .up_rd_req(up_rd_req), .up_rd_dout(d2_rd_dout), .up_rd_ack(d2_rd_ack),
    .ctrl_scratch(d2_scratch), .ctrl_rtc_mode(d2_rtc_mode),
    .ctrl_second(d2_second), .ctrl_nanosecond(d2_nanosecond),
    .ctrl_timeset(d2_timeset), .ctrl_timeget(d2_timeget), .ctrl_second_inc(d2_second_inc),
    .stat_second(stat_second), .stat_nanosecond(stat_nanosecond),
    .ctrl_trig_enable(d2_trig_enable), .ctrl_trig_source(d2_trig_source),
    .ctrl_trig_type(d2_trig_type), .ctrl_trig_second(d2_trig_second),
    .ctrl_trig_nanosecond(d2_trig_nanosecond), .ctrl_trig_load(d2_trig_load),
    .stat_trig_fired(stat_trig_fired[0:0]), .irq(d2_irq)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] data;
    string       nm;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Driver tasks: return #1 after the edge that sampled the request.
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
    tick();
    up_wr_addr = a; up_wr_din = d; up_wr_req = 1'b1;
    tick();
    up_wr_req = 1'b0;
    check("wr_ack", up_wr_ack, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    exp_q.push_back(exp);
    tick();
    up_rd_addr = a; up_rd_req = 1'b1;
    tick();
    up_rd_req = 1'b0;
    check({nm, "_ack"}, up_rd_ack, 1);
    e = exp_q.pop_front();
    check(nm, up_rd_dout, e);
  endtask

  task automatic fire(input logic [NT-1:0] m);
    tick();
    stat_trig_fired = m;
    tick();
    stat_trig_fired = '0;
  endtask

  function automatic void add(input bit wr, input logic [9:0] a, input logic [31:0] d, input string nm);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.nm = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    add(1, 8,   32'hA5A5_0001, "w_scratch");
    add(0, 8,   32'hA5A5_0001, "r_scratch");
    add(0, 9,   32'hDEAD_BEEF, "r_unmapped9");
    add(0, 1,   32'h1588_0002, "r_product");
    add(1, 16,  32'hFFFF_FFFF, "w_rtc_mode");
    add(0, 16,  32'h0000_0001, "r_rtc_mode");
    add(1, 17,  32'h1234_5678, "w_second");
    add(0, 17,  32'h1234_5678, "r_second");
    add(1, 18,  32'h3B9A_C9FF, "w_ns");
    add(0, 18,  32'h3B9A_C9FF, "r_ns");
    add(0, 19,  32'h0000_0000, "r_timeset");
    add(0, 20,  32'h0000_0000, "r_timeget");
    add(0, 23,  32'h0000_0000, "r_second_inc");
    add(1, 64,  32'hFFFF_FFFF, "w_ch0_ctrl");
    add(0, 64,  32'h0000_0037, "r_ch0_ctrl");
    add(1, 80,  32'h0000_0012, "w_ch2_ctrl");
    add(0, 80,  32'h0000_0012, "r_ch2_ctrl");
    add(0, 71,  32'hDEAD_BEEF, "r_ch0_off7");
    add(0, 96,  32'hDEAD_BEEF, "r_ch4");
    add(0, 7,   32'hDEAD_BEEF, "r_unmapped7");

    repeat (3) tick();
    // Reset state, while still in reset and after release
    check("rst_wr_ack",  up_wr_ack, 0);
    check("rst_rd_ack",  up_rd_ack, 0);
    check("rst_dout",    up_rd_dout, 0);
    check("rst_scratch", ctrl_scratch, 0);
    check("rst_pulses",  {ctrl_timeset, ctrl_timeget, ctrl_second_inc, ctrl_rtc_mode}, 0);
    check("rst_trig",    {ctrl_trig_enable, ctrl_trig_source, ctrl_trig_type, ctrl_trig_load}, 0);
    check("rst_trig_time", ctrl_trig_second[1] | ctrl_trig_nanosecond[3], 0);
    check("rst_irq",     irq, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ack", {up_wr_ack, up_rd_ack}, 0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
      else            do_read(vecs[i].addr, vecs[i].data, vecs[i].nm);
    end
    check("out_scratch",  ctrl_scratch, 32'hA5A5_0001);
    check("out_rtc_mode", ctrl_rtc_mode, 1);
    check("out_enable",   ctrl_trig_enable, 4'b0001);
    check("out_src0",     ctrl_trig_source[0], 2'b11);
    check("out_src2",     ctrl_trig_source[2], 2'b01);
    check("out_type2",    ctrl_trig_type[2], 2'b01);

    // Single-cycle command pulses
    do_write(19, 32'h1);
    check("timeset_hi", {ctrl_timeset, ctrl_timeget, ctrl_second_inc}, 3'b100);
    tick();
    check("timeset_lo", ctrl_timeset, 0);
    do_write(20, 32'h0);
    check("timeget_bit0_0", ctrl_timeget, 0);
    do_write(23, 32'h3);
    check("second_inc_hi", ctrl_second_inc, 1);
    tick();
    check("second_inc_lo", ctrl_second_inc, 0);

    // Atomic snapshot
    stat_second = 32'd100; stat_nanosecond = 32'd5;
    do_read(21, 32'd100, "snap_sec");
    stat_nanosecond = 32'd900; stat_second = 32'd101;
    do_read(22, 32'd5, "snap_ns");

    // Shadow/commit on channel 1
    do_write(73, 32'd7);
    do_write(74, 32'd500);
    check("shadow_no_effect", {ctrl_trig_second[1], ctrl_trig_nanosecond[1]}, 0);
    do_read(73, 32'd7, "r_shadow_sec");
    do_write(75, 32'h0);
    check("commit_bit0_0", {ctrl_trig_load, ctrl_trig_second[1]}, 0);
    do_write(75, 32'h1);
    check("commit_load",   ctrl_trig_load, 4'b0010);
    check("commit_sec",    ctrl_trig_second[1], 32'd7);
    check("commit_ns",     ctrl_trig_nanosecond[1], 32'd500);
    tick();
    check("commit_load_lo", ctrl_trig_load, 0);
    do_read(76, 32'd7, "r_active_sec");
    do_read(77, 32'd500, "r_active_ns");
    do_read(128, 32'hDEAD_BEEF, "r_addr128");

    // Fire counters; dut2 has a 2-bit counter
    repeat (3) fire(4'b0001);
    do_read(70, 32'd3, "cnt3");
    check("cnt3_w2", d2_rd_dout, 32'd3);
    repeat (2) fire(4'b0001);
    do_read(70, 32'd5, "cnt5");
    check("cnt_sat_w2", d2_rd_dout, 32'd3);
    do_read(78, 32'd0, "cnt_ch1_zero");
    tick();
    up_wr_addr = 70; up_wr_din = 32'h0; up_wr_req = 1'b1; stat_trig_fired = 4'b0001;
    tick();
    up_wr_req = 1'b0; stat_trig_fired = '0;
    do_read(70, 32'd1, "cnt_clr_fire");
    check("cnt_clr_fire_w2", d2_rd_dout, 32'd1);
    do_write(70, 32'hFFFF);
    do_read(70, 32'd0, "cnt_clr");

`ifdef COREBOARD1588_TRIG_IRQ_EN
    do_write(24, 32'hF);
    do_write(25, 32'h1);
    do_read(24, 32'h0, "irq_sts_clr");
    do_read(25, 32'h1, "irq_mask");
    fire(4'b0010);
    check("irq_masked", irq, 0);
    fire(4'b0001);
    check("irq_set", irq, 1);
    tick();
    up_wr_addr = 24; up_wr_din = 32'h1; up_wr_req = 1'b1; stat_trig_fired = 4'b0001;
    tick();
    up_wr_req = 1'b0; stat_trig_fired = '0;
    check("irq_w1c_fire", irq, 1);
    do_read(24, 32'h3, "irq_sts_kept");
    do_write(24, 32'h1);
    check("irq_cleared", irq, 0);
    do_read(24, 32'h2, "irq_sts_after");
`else
    do_read(24, 32'hDEAD_BEEF, "irq_sts_unmapped");
    do_read(25, 32'hDEAD_BEEF, "irq_mask_unmapped");
    do_write(25, 32'hF);
    fire(4'b0001);
    check("irq_tied0", irq, 0);
`endif

    // Request coincident with reset is dropped
    tick();
    rst = 1'b1; up_wr_addr = 8; up_wr_din = 32'h1234; up_wr_req = 1'b1;
    up_rd_addr = 8; up_rd_req = 1'b1;
    tick();
    rst = 1'b0; up_wr_req = 1'b0; up_rd_req = 1'b0;
    check("rst_req_acks", {up_wr_ack, up_rd_ack}, 0);
    check("rst_req_scratch", ctrl_scratch, 0);
    tick();
    check("rst_req_acks_late", {up_wr_ack, up_rd_ack}, 0);
    check("rst_req_scratch_late", ctrl_scratch, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
